// File: rtl/hex_bus_sequencer.sv
// ============================================================================
// Module   : hex_bus_sequencer
// Brief    : Accepts a hex word over valid/ready and time-multiplexes it one
//            nibble per dwell onto a 4-bit decoder bus with command/digit_sel.
//            Optional macro SEQ_BLANK_LEADING_ZEROS_EN blanks leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_bus_sequencer #(
  parameter int         DIGITS      = 4,
  parameter int         DWELL       = 50000,
  parameter logic [4:0] CMD_DISPLAY = 5'b00000,
  parameter logic [4:0] CMD_BLANK   = 5'b11111
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic [3:0]            bus,
  output logic [4:0]            command,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int CW = (DWELL  > 1) ? $clog2(DWELL)  : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int WW = 4 * DIGITS;

  localparam logic [0:0]    c_IDLE     = 1'b0;
  localparam logic [0:0]    c_SCAN     = 1'b1;
  localparam logic [CW-1:0] c_CNT_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] c_IDX_LAST = IW'(DIGITS - 1);

  logic [0:0]        r_state;
  logic [WW-1:0]     r_disp;
  logic [WW-1:0]     r_shadow;
  logic              r_pend;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_cnt;
  logic [3:0]        r_bus;
  logic [4:0]        r_cmd;
  logic [DIGITS-1:0] r_sel;
  logic              r_fd;

  logic              w_dwell_end;
  logic              w_wrap;
  logic [IW-1:0]     w_next_idx;
  logic [IW-1:0]     w_tgt_idx;
  logic [WW-1:0]     w_tgt_word;
  logic [3:0]        w_nib;
  logic [DIGITS-1:0] w_sel;
  logic              w_blank;

  // The block can always take a word: it either starts scanning or lands in the shadow.
  assign in_ready    = 1'b1;

  assign w_dwell_end = (r_cnt == c_CNT_LAST);
  assign w_wrap      = w_dwell_end && (r_idx == c_IDX_LAST);
  assign w_next_idx  = w_wrap ? '0 : r_idx + 1'b1;

  // Digit and word that become current on this edge if the outputs are reloaded.
  always_comb begin
    w_tgt_idx  = w_next_idx;
    w_tgt_word = r_disp;
    if (r_state == c_IDLE) begin
      w_tgt_idx  = '0;
      w_tgt_word = in_data;
    end else if (w_wrap) begin
      if (in_valid)    w_tgt_word = in_data;
      else if (r_pend) w_tgt_word = r_shadow;
    end
  end

  assign w_nib = w_tgt_word[{w_tgt_idx, 2'b00} +: 4];
  assign w_sel = DIGITS'(1) << w_tgt_idx;

`ifdef SEQ_BLANK_LEADING_ZEROS_EN
  logic [DIGITS-1:0] w_hi_zero;

  for (genvar k = 0; k < DIGITS; k++) begin : g_hi_zero
    assign w_hi_zero[k] = (w_tgt_word[WW-1:4*k] == '0);
  end

  assign w_blank = (w_tgt_idx != '0) && w_hi_zero[w_tgt_idx];
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_disp   <= '0;
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_bus    <= 4'h0;
      r_cmd    <= CMD_BLANK;
      r_sel    <= '0;
      r_fd     <= 1'b0;
    end else begin
      r_fd <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_state <= c_SCAN;
            r_disp  <= in_data;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_bus   <= w_blank ? 4'h0 : w_nib;
            r_cmd   <= w_blank ? CMD_BLANK : CMD_DISPLAY;
            r_sel   <= w_sel;
          end
        end
        c_SCAN: begin
          if (w_dwell_end) begin
            r_cnt  <= '0;
            r_idx  <= w_next_idx;
            r_disp <= w_tgt_word;
            r_bus  <= w_blank ? 4'h0 : w_nib;
            r_cmd  <= w_blank ? CMD_BLANK : CMD_DISPLAY;
            r_sel  <= w_sel;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          // A wrap consumes the shadow (or bypasses it); otherwise accepts are last-wins.
          if (w_wrap) begin
            r_pend <= 1'b0;
            r_fd   <= 1'b1;
          end else if (in_valid) begin
            r_shadow <= in_data;
            r_pend   <= 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus        = r_bus;
  assign command    = r_cmd;
  assign digit_sel  = r_sel;
  assign frame_done = r_fd;
  assign pending    = r_pend;

endmodule

`default_nettype wire

// File: tb/tb_hex_bus_sequencer.sv
// ============================================================================
// Module   : tb_hex_bus_sequencer
// Brief    : Directed plus randomized bench for hex_bus_sequencer against a
//            frame-position reference model (DIGITS=4, DWELL=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_bus_sequencer;

  localparam int DIGITS = 4;
  localparam int DWELL  = 4;
  localparam int FRAME  = DIGITS * DWELL;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  bus;
  logic [4:0]  command;
  logic [3:0]  digit_sel;
  logic        frame_done;
  logic        pending;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: frame position is a single tick count within the frame.
  bit          m_run;
  logic [15:0] m_word;
  logic [15:0] m_shadow;
  bit          m_pend;
  int          m_t;
  bit          m_fd;

  hex_bus_sequencer #(
    .DIGITS      (DIGITS),
    .DWELL       (DWELL),
    .CMD_DISPLAY (5'b00000),
    .CMD_BLANK   (5'b11111)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .bus        (bus),
    .command    (command),
    .digit_sel  (digit_sel),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic vld, input logic [15:0] data);
    bit wrap;
    if (!rst) begin
      m_run = 0; m_word = '0; m_shadow = '0; m_pend = 0; m_t = 0; m_fd = 0;
    end else if (!m_run) begin
      m_fd = 0;
      if (vld) begin
        m_run  = 1;
        m_word = data;
        m_t    = 0;
      end
    end else begin
      wrap = (m_t == FRAME - 1);
      m_t  = (m_t + 1) % FRAME;
      m_fd = wrap;
      if (wrap) begin
        if (vld)         m_word = data;
        else if (m_pend) m_word = m_shadow;
        m_pend = 0;
      end else if (vld) begin
        m_shadow = data;
        m_pend   = 1;
      end
    end
  endtask

  task automatic compare_all(input logic rst);
    int          digit;
    logic [15:0] upper;
    bit          blank;
    if (!m_run) begin
      check("bus_idle", bus, 0);
      check("cmd_idle", command, 5'b11111);
      check("sel_idle", digit_sel, 0);
    end else begin
      digit = m_t / DWELL;
      upper = m_word >> (4 * digit);
      blank = 0;
`ifdef SEQ_BLANK_LEADING_ZEROS_EN
      blank = (digit != 0) && (upper == 16'h0);
`endif
      check("bus", bus, blank ? 4'h0 : upper[3:0]);
      check("cmd", command, blank ? 5'b11111 : 5'b00000);
      check("sel", digit_sel, 4'b0001 << digit);
    end
    check("frame_done", frame_done, m_fd);
    check("pending", pending, m_pend);
    if (rst) check("in_ready", in_ready, 1'b1);
  endtask

  task automatic tick(input logic rst, input logic vld, input logic [15:0] data);
    rst_n    = rst;
    in_valid = vld;
    in_data  = data;
    @(posedge clk);
    model_step(rst, vld, data);
    #1;
    compare_all(rst);
  endtask

  // Idle until the model frame position reaches target (bounded).
  task automatic idle_to(input int target);
    for (int i = 0; i < 4 * FRAME && m_t != target; i++) tick(1'b1, 1'b0, 16'h0);
    check("idle_to_reached", m_t, target);
  endtask

  initial begin
    logic [15:0] d;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    m_run = 0; m_word = '0; m_shadow = '0; m_pend = 0; m_t = 0; m_fd = 0;

    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 16'hFFFF);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 16'h0);

    // First word from IDLE, zero added latency.
    tick(1'b1, 1'b1, 16'hA3C5);
    check("first_nibble", bus, 4'h5);
    check("first_sel", digit_sel, 4'b0001);
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, 16'h0);
    check("wrap_back_digit0", bus, 4'h5);

    // Last-wins shadow while running.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 16'h1234);
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 16'h5678);
    idle_to(0);
    check("shadow_word_shown", bus, 4'h8);
    check("pending_cleared", pending, 1'b0);

    // Accept exactly on the wrap edge bypasses the shadow.
    idle_to(FRAME - 1);
    tick(1'b1, 1'b1, 16'h00FF);
    check("bypass_nibble", bus, 4'hF);

    // Reset mid digit 2, then restart.
    idle_to(9);
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 16'hBEEF);
    check("restart_nibble", bus, 4'hF);

    // Leading-zero words (blanked only when the option is built in).
    idle_to(FRAME - 1);
    tick(1'b1, 1'b1, 16'h0005);
    idle_to(FRAME - 1);
    tick(1'b1, 1'b1, 16'h0000);
    idle_to(FRAME - 1);
    tick(1'b1, 1'b0, 16'h0);

    for (int i = 0; i < 1200; i++) begin
      d = 16'($urandom);
      d = d >> $urandom_range(0, 16);
      tick($urandom_range(0, 149) != 0, $urandom_range(0, 5) == 0, d);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hex_bus_sequencer.md
Name: hex_bus_sequencer

Overview:
- Upstream feeder for the seven-segment decoder stage.
- Accepts a multi-digit hex word over a valid/ready handshake and holds it.
- Time-multiplexes the word one nibble at a time onto the decoder's 4-bit `bus`, with a matching `command` code and a one-hot digit select.
- Each digit is held for a programmable dwell, and new words only take effect on frame boundaries, so a displayed frame is never torn.

Parameters:
- DIGITS, 4, number of hex digits per word; legal range 1..8.
- DWELL, 50000, clock cycles each digit is held; minimum 1.
- CMD_DISPLAY, 5'b00000, command code that enables nibble decode downstream.
- CMD_BLANK, 5'b11111, command code driven when no digit is valid or the digit is suppressed.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  `in_data` is valid.
- in_ready  output  1  block can accept a word.
- in_data  input  4*DIGITS  hex word; nibble 0 = bits [3:0], least significant.
- bus  output  4  current nibble to the decoder.
- command  output  5  CMD_DISPLAY or CMD_BLANK.
- digit_sel  output  DIGITS  one-hot select of the digit currently driven on `bus`.
- frame_done  output  1  one-cycle pulse when the last digit's dwell ends.
- pending  output  1  a word is waiting in the shadow register.

Behaviour:
- Interface: one clock (`clk`); reset is synchronous and active-low (`rst_n`); every register updates only on a rising `clk` edge.
- All outputs are driven directly from registers, except `in_ready`, which is tied to 1 out of reset.
- Reset, sampled at any edge in any state:
  - state=IDLE, display register=0, shadow register=0, pending=0, digit index=0, dwell counter=0.
  - bus=0, command=CMD_BLANK, digit_sel=0, frame_done=0.
  - During the reset cycle, `in_ready` is ignored.
  - Reset mid-frame discards both the held word and any pending word.
- Accept: occurs when `in_valid && in_ready` on an edge. `in_ready` is 1 in both states.
- IDLE:
  - Outputs are held at their reset values.
  - On accept: state<=SCAN, display<=in_data, idx<=0, cnt<=0, bus<=in_data[3:0], command<=CMD_DISPLAY, digit_sel<=1.
  - Latency: the new nibble is visible the cycle after the accept edge.
- SCAN, each edge:
  - If cnt<DWELL-1: cnt<=cnt+1 and the outputs hold.
  - If cnt==DWELL-1: cnt<=0 and idx advances. Outputs update on the same edge to the new idx: bus=display[4*idx+3:4*idx], digit_sel=1<<idx, command=CMD_DISPLAY.
  - Index wrap: when idx==DIGITS-1 at the end of its dwell, idx<=0 and frame_done<=1 for exactly one cycle; otherwise frame_done<=0.
  - At wrap: if pending==1, display<=shadow and pending<=0. The digit-0 outputs of the new frame use the new word.
- Accept while in SCAN, not on a wrap edge: shadow<=in_data, pending<=1. A later accept before the wrap overwrites the shadow (last-wins; earlier words are dropped).
- Accept on the same edge as a wrap: in_data bypasses the shadow into display, pending<=0, and any older shadow content is discarded.
- The block never returns to IDLE except via reset.
- DIGITS==1:
  - Every dwell end is a wrap; frame_done pulses every DWELL cycles.
  - digit_sel stays at 1'b1.
- DWELL==1: the digit changes every cycle and cnt stays at 0.
- Widths:
  - cnt is $clog2(DWELL) bits, minimum 1.
  - idx is $clog2(DIGITS) bits, minimum 1.
  - Nibble selection uses an indexed part-select on display.

Optional Feature:
- Macro: SEQ_BLANK_LEADING_ZEROS_EN.
- Defined:
  - When a digit becomes current, it is forced to command=CMD_BLANK if that digit and every more-significant digit are 0. In that case bus=0, and digit_sel still advances normally.
  - Digit 0 is always CMD_DISPLAY.
  - Suppression is evaluated against the display register, not the shadow.
- Undefined: every digit is driven with CMD_DISPLAY.
- Timing is identical in both builds.

Test Plan:
All scenarios use DIGITS=4, DWELL=4.
- Reset then idle 10 cycles -> bus=0, command=5'b11111, digit_sel=0, frame_done never 1.
- Accept 16'hA3C5 in IDLE -> next cycle bus=5, digit_sel=4'b0001, command=0. After 4 cycles bus=C / sel 0010, then 3 / 0100, then A / 1000. frame_done pulses once at cycle 16, then bus=5 / sel 0001.
- Running 16'hA3C5, accept 16'h1234 at cycle 6 and 16'h5678 at cycle 9 -> pending=1 from cycle 7; digits A/3/C continue unchanged; at the wrap bus=8, pending=0; 16'h1234 is never displayed.
- Accept 16'h00FF on exactly the wrap edge of a running frame -> next cycle bus=F, sel 0001, pending stays 0.
- rst_n=0 for one edge mid-digit-2 -> the following cycle shows reset values; a subsequent accept restarts at digit 0 with zero latency as in IDLE.
- With SEQ_BLANK_LEADING_ZEROS_EN, accept 16'h0005 -> digit 0 bus=5, command=0; digits 1-3 command=5'b11111, bus=0. Accept 16'h0000 -> digit 0 command=0, bus=0; digits 1-3 blank.
